tile_wr_sink: RTL and testbench

Delivery-side write sink for one mesh tile. Consumes the write-request stream emitted by the tile's XY router FIFO once a request has reached its destination tile (a valid strobe plus data, 43-bit global address and size). It decodes each request into a byte-lane write, merges back-to-back writes to the same 64-bit word, buffers them in a 4-entry FIFO and drains them to the tile's local memory port under a ready handshake. It flags misrouted, misaligned and overflowed requests.

---
 rtl/tile_wr_sink.sv | 199 +++++++++++++++++++
 tb/tb_tile_wr_sink.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_wr_sink.sv
// Write sink for one mesh tile: decodes router write requests into byte-lane writes,
// merges same-word writes, buffers them in a 4-entry FIFO and drains to local memory.
module tile_wr_sink #(
   parameter logic [4:0] tile_X = 5'd0,
   parameter logic [4:0] tile_Y = 5'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_vld,
   input  logic [73:0] in_data,
   input  logic [42:0] in_addr,
   input  logic [1:0]  in_size,
   output logic        in_hold,
   output logic        mem_wr_en,
   output logic [29:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_be,
   output logic [9:0]  mem_tag,
   input  logic        mem_ready,
   output logic [7:0]  err_cnt,
   output logic [15:0] wr_cnt,
   output logic        ovf
);

   // ---------------- request decode (feeds S1) ----------------
   logic [2:0]  in_off;
   logic        dec_hit;
   logic        dec_aligned;
   logic [7:0]  dec_be_base;
   logic [63:0] dec_mask;

   assign in_off  = in_addr[2:0];
   assign dec_hit = (in_addr[42:38] == tile_Y) && (in_addr[37:33] == tile_X);

   always_comb begin
      dec_aligned = 1'b1;
      dec_be_base = 8'h01;
      dec_mask    = 64'h0000_0000_0000_00FF;
      case (in_size)
         2'd0: begin
         end
         2'd1: begin
            dec_aligned = ~in_off[0];
            dec_be_base = 8'h03;
            dec_mask    = 64'h0000_0000_0000_FFFF;
         end
         2'd2: begin
            dec_aligned = (in_off[1:0] == 2'b00);
            dec_be_base = 8'h0F;
            dec_mask    = 64'h0000_0000_FFFF_FFFF;
         end
         default: begin
            dec_aligned = (in_off == 3'd0);
            dec_be_base = 8'hFF;
            dec_mask    = 64'hFFFF_FFFF_FFFF_FFFF;
         end
      endcase
   end

   // ---------------- S1 decode register ----------------
   logic        s1_vld_q,   s1_vld_d;
   logic        s1_ok_q,    s1_ok_d;
   logic [7:0]  s1_be_q,    s1_be_d;
   logic [63:0] s1_wdata_q, s1_wdata_d;
   logic [29:0] s1_waddr_q, s1_waddr_d;
   logic [9:0]  s1_tag_q,   s1_tag_d;

   always_comb begin
      s1_vld_d   = in_vld;
      s1_ok_d    = dec_hit & dec_aligned;
      s1_be_d    = dec_be_base << in_off;
      s1_wdata_d = (in_data[63:0] & dec_mask) << {in_off, 3'b000};
      s1_waddr_d = in_addr[32:3];
      s1_tag_d   = in_data[73:64];
   end

   // ---------------- FIFO storage and control ----------------
   logic [29:0] f_addr_q  [4];
   logic [29:0] f_addr_d  [4];
   logic [63:0] f_wdata_q [4];
   logic [63:0] f_wdata_d [4];
   logic [7:0]  f_be_q    [4];
   logic [7:0]  f_be_d    [4];
   logic [9:0]  f_tag_q   [4];
   logic [9:0]  f_tag_d   [4];

   logic [1:0]  wr_ptr_q,  wr_ptr_d;
   logic [1:0]  rd_ptr_q,  rd_ptr_d;
   logic [2:0]  count_q,   count_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic [15:0] wr_cnt_q,  wr_cnt_d;
   logic        ovf_q,     ovf_d;

   logic [1:0]  tail_idx;
   logic        pop;
   logic        s1_good;
   logic        s1_bad;
   logic        merge;
   logic        push;
   logic        drop_full;
   logic [63:0] merge_wdata;

   assign tail_idx = wr_ptr_q - 2'd1;
   assign pop      = mem_wr_en & mem_ready;
   assign s1_good  = s1_vld_q & s1_ok_q;
   assign s1_bad   = s1_vld_q & ~s1_ok_q;

   // A tail that is also the head being popped this cycle cannot absorb a merge.
   assign merge     = s1_good && (count_q != 3'd0) && (f_addr_q[tail_idx] == s1_waddr_q)
                      && ((count_q >= 3'd2) || !pop);
   assign push      = s1_good && !merge && ((count_q != 3'd4) || pop);
   assign drop_full = s1_good && !merge && (count_q == 3'd4) && !pop;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         assign merge_wdata[gi*8 +: 8] = s1_be_q[gi] ? s1_wdata_q[gi*8 +: 8]
                                                     : f_wdata_q[tail_idx][gi*8 +: 8];
      end
   endgenerate

   always_comb begin
      f_addr_d  = f_addr_q;
      f_wdata_d = f_wdata_q;
      f_be_d    = f_be_q;
      f_tag_d   = f_tag_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q + {2'b00, push} - {2'b00, pop};
      err_cnt_d = err_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      ovf_d     = ovf_q | drop_full;

      if (merge) begin
         f_wdata_d[tail_idx] = merge_wdata;
         f_be_d[tail_idx]    = f_be_q[tail_idx] | s1_be_q;
         f_tag_d[tail_idx]   = s1_tag_q;
      end
      if (push) begin
         f_addr_d[wr_ptr_q]  = s1_waddr_q;
         f_wdata_d[wr_ptr_q] = s1_wdata_q;
         f_be_d[wr_ptr_q]    = s1_be_q;
         f_tag_d[wr_ptr_q]   = s1_tag_q;
         wr_ptr_d            = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
         wr_cnt_d = wr_cnt_q + 16'd1;
      end
      if (s1_bad && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         wr_ptr_q  <= 2'd0;
         rd_ptr_q  <= 2'd0;
         count_q   <= 3'd0;
         err_cnt_q <= 8'd0;
         wr_cnt_q  <= 16'd0;
         ovf_q     <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         err_cnt_q <= err_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   // Payload storage needs no reset: it is only observed through a nonzero count.
   always_ff @(posedge clk) begin
      s1_ok_q    <= s1_ok_d;
      s1_be_q    <= s1_be_d;
      s1_wdata_q <= s1_wdata_d;
      s1_waddr_q <= s1_waddr_d;
      s1_tag_q   <= s1_tag_d;
      f_addr_q   <= f_addr_d;
      f_wdata_q  <= f_wdata_d;
      f_be_q     <= f_be_d;
      f_tag_q    <= f_tag_d;
   end

   // ---------------- outputs ----------------
   assign mem_wr_en = (count_q != 3'd0);
   assign mem_addr  = mem_wr_en ? f_addr_q[rd_ptr_q]  : 30'd0;
   assign mem_wdata = mem_wr_en ? f_wdata_q[rd_ptr_q] : 64'd0;
   assign mem_be    = mem_wr_en ? f_be_q[rd_ptr_q]    : 8'd0;
   assign mem_tag   = mem_wr_en ? f_tag_q[rd_ptr_q]   : 10'd0;
   assign in_hold   = ({1'b0, count_q} + {3'b000, s1_vld_q}) >= 4'd3;
   assign err_cnt   = err_cnt_q;
   assign wr_cnt    = wr_cnt_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_tile_wr_sink.sv
// Bench for tile_wr_sink: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_tile_wr_sink;

   localparam logic [4:0] TX = 5'd3;
   localparam logic [4:0] TY = 5'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_vld;
   logic [73:0] in_data;
   logic [42:0] in_addr;
   logic [1:0]  in_size;
   logic        in_hold;
   logic        mem_wr_en;
   logic [29:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_be;
   logic [9:0]  mem_tag;
   logic        mem_ready;
   logic [7:0]  err_cnt;
   logic [15:0] wr_cnt;
   logic        ovf;

   tile_wr_sink #(.tile_X(TX), .tile_Y(TY)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_addr(in_addr),
      .in_size(in_size), .in_hold(in_hold), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_tag(mem_tag), .mem_ready(mem_ready),
      .err_cnt(err_cnt), .wr_cnt(wr_cnt), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [29:0] addr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic [9:0]  tag;
   } ent_t;

   ent_t        mq[$];
   ent_t        m_s1;
   bit          m_s1_v  = 1'b0;
   bit          m_s1_ok = 1'b0;
   int          m_err   = 0;
   logic [15:0] m_wr    = 16'd0;
   bit          m_ovf   = 1'b0;

   function automatic ent_t decode(input logic [42:0] a, input logic [1:0] sz,
                                   input logic [73:0] d, output bit ok);
      ent_t e;
      int nb;
      int off;
      nb  = 1 << sz;
      off = int'(a[2:0]);
      ok  = (a[42:38] == TY) && (a[37:33] == TX) && ((off % nb) == 0);
      e.addr  = a[32:3];
      e.tag   = d[73:64];
      e.be    = '0;
      e.wdata = '0;
      for (int b = 0; b < 8; b++) begin
         if (b >= off && b < off + nb) begin
            e.be[b]          = 1'b1;
            e.wdata[8*b +: 8] = d[8*(b-off) +: 8];
         end
      end
      return e;
   endfunction

   always @(posedge clk) begin : model_p
      bit   do_pop;
      bit   do_push;
      int   n;
      ent_t t;
      if (rst) begin
         mq.delete();
         m_s1_v = 1'b0;
         m_err  = 0;
         m_wr   = 16'd0;
         m_ovf  = 1'b0;
      end else begin
         n       = mq.size();
         do_pop  = (n != 0) && mem_ready;
         do_push = 1'b0;
         if (m_s1_v) begin
            if (!m_s1_ok) begin
               if (m_err < 255) m_err++;
            end else if (n != 0 && mq[n-1].addr == m_s1.addr && !(do_pop && n == 1)) begin
               t = mq[n-1];
               for (int b = 0; b < 8; b++)
                  if (m_s1.be[b]) t.wdata[8*b +: 8] = m_s1.wdata[8*b +: 8];
               t.be    = t.be | m_s1.be;
               t.tag   = m_s1.tag;
               mq[n-1] = t;
            end else if (n < 4 || do_pop) begin
               do_push = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (do_pop) begin
            void'(mq.pop_front());
            m_wr++;
         end
         if (do_push) mq.push_back(m_s1);
         m_s1_v = in_vld;
         if (in_vld) m_s1 = decode(in_addr, in_size, in_data, m_s1_ok);
      end
   end

   always @(negedge clk) begin : compare_p
      ent_t h;
      if (chk_en) begin
         h = (mq.size() != 0) ? mq[0] : '0;
         chk("m_wr_en", {63'd0, mem_wr_en}, {63'd0, mq.size() != 0});
         chk("m_addr",  {34'd0, mem_addr},  {34'd0, h.addr});
         chk("m_wdata", mem_wdata, h.wdata);
         chk("m_be",    {56'd0, mem_be},    {56'd0, h.be});
         chk("m_tag",   {54'd0, mem_tag},   {54'd0, h.tag});
         chk("m_hold",  {63'd0, in_hold},   {63'd0, (mq.size() + int'(m_s1_v)) >= 3});
         chk("m_err",   {56'd0, err_cnt},   64'(m_err));
         chk("m_wrcnt", {48'd0, wr_cnt},    {48'd0, m_wr});
         chk("m_ovf",   {63'd0, ovf},       {63'd0, m_ovf});
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [42:0] la(input logic [32:0] a);
      return {TY, TX, a};
   endfunction

   task automatic req(input logic [42:0] a, input logic [1:0] s, input logic [63:0] p,
                      input logic [9:0] t);
      in_vld  = 1'b1;
      in_addr = a;
      in_size = s;
      in_data = {t, p};
      @(negedge clk);
      in_vld  = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_vld = 1'b0; in_data = '0; in_addr = '0; in_size = '0; mem_ready = 1'b1;
      step(2);
      chk_en = 1'b1;
      chk("rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
      chk("rst_hold",  {63'd0, in_hold},   64'd0);
      chk("rst_be",    {56'd0, mem_be},    64'd0);
      chk("rst_wrcnt", {48'd0, wr_cnt},    64'd0);
      chk("rst_err",   {56'd0, err_cnt},   64'd0);
      rst = 1'b0;

      // single 8-byte write
      req(la(33'h10), 2'd3, 64'h1122334455667788, 10'h001);
      step(1);
      chk("single_wr_en", {63'd0, mem_wr_en}, 64'd1);
      chk("single_addr",  {34'd0, mem_addr},  64'h2);
      chk("single_be",    {56'd0, mem_be},    64'hFF);
      chk("single_wdata", mem_wdata, 64'h1122334455667788);
      step(1);
      chk("single_wrcnt", {48'd0, wr_cnt}, 64'd1);

      // byte lane held under backpressure
      do_reset();
      mem_ready = 1'b0;
      req(la(33'h15), 2'd0, 64'hAB, 10'h002);
      step(1);
      for (int i = 0; i < 4; i++) begin
         chk("lane_be",    {56'd0, mem_be}, 64'h20);
         chk("lane_wdata", mem_wdata, 64'h0000AB0000000000);
         step(1);
      end
      mem_ready = 1'b1;
      step(1);
      chk("lane_wrcnt", {48'd0, wr_cnt}, 64'd1);

      // merge of two bytes into one word
      do_reset();
      mem_ready = 1'b0;
      req(la(33'h40), 2'd0, 64'h11, 10'h005);
      req(la(33'h41), 2'd0, 64'h22, 10'h006);
      step(1);
      chk("merge_be",  {56'd0, mem_be}, 64'h03);
      chk("merge_lo",  {48'd0, mem_wdata[15:0]}, 64'h2211);
      chk("merge_tag", {54'd0, mem_tag}, 64'h006);
      mem_ready = 1'b1;
      step(1);
      chk("merge_wrcnt", {48'd0, wr_cnt}, 64'd1);

      // misrouted and misaligned drops, then saturation
      do_reset();
      req({TY, 5'd4, 33'h8}, 2'd3, 64'h1, 10'h0);
      req(la(33'h2), 2'd2, 64'h2, 10'h0);
      step(2);
      chk("err_two",   {56'd0, err_cnt},   64'd2);
      chk("err_no_wr", {63'd0, mem_wr_en}, 64'd0);
      for (int i = 0; i < 300; i++) req({TY, 5'd4, 33'h8}, 2'd3, 64'h1, 10'h0);
      step(2);
      chk("err_sat", {56'd0, err_cnt}, 64'd255);

      // overflow while ignoring in_hold, then ordered drain
      do_reset();
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         req(la(33'h80 + 33'(8*i)), 2'd3, 64'(i + 1), 10'(i));
         chk("ovf_hold", {63'd0, in_hold}, {63'd0, i >= 2});
      end
      step(1);
      chk("ovf_set", {63'd0, ovf}, 64'd1);
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("ovf_order", {34'd0, mem_addr}, 64'(30'h10 + 30'(i)));
         step(1);
      end
      chk("ovf_wrcnt", {48'd0, wr_cnt},    64'd4);
      chk("ovf_empty", {63'd0, mem_wr_en}, 64'd0);

      // reset while three entries are queued
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) req(la(33'h200 + 33'(8*i)), 2'd3, 64'hC0DE, 10'h3);
      step(1);
      chk("mid_queued", {63'd0, mem_wr_en}, 64'd1);
      mem_ready = 1'b1;
      rst = 1'b1;
      step(1);
      chk("mid_wr_en", {63'd0, mem_wr_en}, 64'd0);
      chk("mid_wrcnt", {48'd0, wr_cnt},    64'd0);
      chk("mid_ovf",   {63'd0, ovf},       64'd0);
      rst = 1'b0;
      req(la(33'h300), 2'd3, 64'hFEED, 10'h7);
      step(1);
      chk("post_addr", {34'd0, mem_addr}, 64'h60);
      step(1);
      chk("post_wrcnt", {48'd0, wr_cnt}, 64'd1);

      // full FIFO popping in the same cycle accepts the push
      do_reset();
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) req(la(33'h400 + 33'(8*i)), 2'd3, 64'(i), 10'(i));
      mem_ready = 1'b1;
      step(1);
      chk("fullpop_ovf",  {63'd0, ovf},      64'd0);
      chk("fullpop_head", {34'd0, mem_addr}, 64'h81);
      step(4);
      chk("fullpop_wrcnt", {48'd0, wr_cnt}, 64'd5);

      // mixed sizes and offsets with intermittent ready
      do_reset();
      for (int i = 0; i < 16; i++) begin
         int nb;
         int off;
         nb        = 1 << (i % 4);
         off       = (i * nb) % 8;
         mem_ready = (i % 3) != 0;
         req(la(33'h1000 + 33'(8*(i/3)) + 33'(off)), 2'(i % 4),
             64'h8877665544332211 + 64'(i), 10'(i));
      end
      mem_ready = 1'b1;
      step(8);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
